// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: divides the board clock by a run-time divisor
// to make the oversample strobe TICK. It also emits a once-per-bit strobe
// BIT_TICK and a mid-bit sample strobe MID_TICK. All three strobes are
// registered single-cycle pulses.
module baud_tick_gen #(
   parameter int CLK_RATE   = 40000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_WIDTH  = 16,
   parameter int DEF_DIV    = CLK_RATE / (BAUD_RATE * OVERSAMPLE)
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 EN,
   input  logic                 DIV_LOAD,
   input  logic [DIV_WIDTH-1:0] DIV_IN,
   input  logic                 PHASE_RST,
   output logic                 TICK,
   output logic                 BIT_TICK,
   output logic                 MID_TICK,
   output logic [DIV_WIDTH-1:0] DIV_OUT
);

   localparam int                   SUB_W    = $clog2(OVERSAMPLE);
   localparam logic [DIV_WIDTH-1:0] DEF_DIVV = DIV_WIDTH'(DEF_DIV);
   localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
   localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(OVERSAMPLE - 1);
   localparam logic [SUB_W-1:0]     SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);

   logic [DIV_WIDTH-1:0] div_reg;
   logic [DIV_WIDTH-1:0] cnt;
   logic [SUB_W-1:0]     sub;
   logic [DIV_WIDTH-1:0] div_last;
   logic                 wrap;

   // Terminal count of the cycle counter; div_reg is never 0, so no underflow.
   assign div_last = div_reg - ONE;
   assign wrap     = (cnt == div_last);
   assign DIV_OUT  = div_reg;

   // Divisor, phase counters and strobes, in strict priority order.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         div_reg  <= DEF_DIVV;
         cnt      <= '0;
         sub      <= '0;
         TICK     <= 1'b0;
         BIT_TICK <= 1'b0;
         MID_TICK <= 1'b0;
      end else if (DIV_LOAD) begin
         // A zero divisor is clamped to divide-by-1.
         div_reg  <= (DIV_IN == '0) ? ONE : DIV_IN;
         cnt      <= '0;
         sub      <= '0;
         TICK     <= 1'b0;
         BIT_TICK <= 1'b0;
         MID_TICK <= 1'b0;
      end else if (PHASE_RST) begin
         cnt      <= '0;
         sub      <= '0;
         TICK     <= 1'b0;
         BIT_TICK <= 1'b0;
         MID_TICK <= 1'b0;
      end else if (!EN) begin
         // Counters hold so an EN gap only stretches the period.
         TICK     <= 1'b0;
         BIT_TICK <= 1'b0;
         MID_TICK <= 1'b0;
      end else if (!wrap) begin
         cnt      <= cnt + ONE;
         TICK     <= 1'b0;
         BIT_TICK <= 1'b0;
         MID_TICK <= 1'b0;
      end else begin
         // OVERSAMPLE is a power of two, so sub wraps naturally.
         cnt      <= '0;
         sub      <= sub + SUB_W'(1);
         TICK     <= 1'b1;
         BIT_TICK <= (sub == SUB_LAST);
         MID_TICK <= (sub == SUB_MID);
      end
   end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at default parameters (divisor 260,
// 16x oversample). Cycle distances are counted in rising edges. Outputs are
// sampled 1 time unit after each rising edge.
module tb_baud_tick_gen;

   logic        CLK = 1'b0;
   logic        reset;
   logic        EN;
   logic        DIV_LOAD;
   logic [15:0] DIV_IN;
   logic        PHASE_RST;
   logic        TICK;
   logic        BIT_TICK;
   logic        MID_TICK;
   logic [15:0] DIV_OUT;

   int checks = 0;
   int errors = 0;
   int n;

   baud_tick_gen dut (
      .CLK       (CLK),
      .reset     (reset),
      .EN        (EN),
      .DIV_LOAD  (DIV_LOAD),
      .DIV_IN    (DIV_IN),
      .PHASE_RST (PHASE_RST),
      .TICK      (TICK),
      .BIT_TICK  (BIT_TICK),
      .MID_TICK  (MID_TICK),
      .DIV_OUT   (DIV_OUT)
   );

   // Clock
   always #5 CLK = ~CLK;

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Count edges until the selected strobe is seen (0=TICK 1=BIT 2=MID).
   // Returns -1 when the budget runs out.
   task automatic count_to(input int sel, output int cnt_out);
      logic hit;
      cnt_out = -1;
      for (int i = 1; i <= 5000; i++) begin
         step();
         hit = (sel == 0) ? TICK : (sel == 1) ? BIT_TICK : MID_TICK;
         if (hit) begin
            cnt_out = i;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b0; EN = 1'b0; DIV_LOAD = 1'b0; DIV_IN = 16'd0; PHASE_RST = 1'b0;
      steps(3);
      chk("rst_strobes", {29'd0, TICK, BIT_TICK, MID_TICK}, 32'd0);
      chk("rst_div", DIV_OUT, 32'd260);

      // Default divisor: ticks every 260, MID at tick 8, BIT at tick 16.
      reset = 1'b1; EN = 1'b1;
      count_to(0, n); chk("def_first_tick", n, 32'd260);
      chk("def_first_bit", BIT_TICK, 32'd0);
      step(); chk("def_tick_width", TICK, 32'd0);
      count_to(0, n); chk("def_tick_period", n, 32'd259);
      count_to(2, n); chk("def_first_mid", n, 32'd1560);
      chk("def_mid_on_tick", TICK, 32'd1);
      count_to(1, n); chk("def_mid_to_bit", n, 32'd2080);
      chk("def_bit_on_tick", TICK, 32'd1);
      chk("def_bit_not_mid", MID_TICK, 32'd0);

      // Load divisor 3 mid-period.
      steps(100);
      DIV_LOAD = 1'b1; DIV_IN = 16'd3; step(); DIV_LOAD = 1'b0;
      chk("d3_div", DIV_OUT, 32'd3);
      chk("d3_tick_low", TICK, 32'd0);
      count_to(0, n); chk("d3_first_tick", n, 32'd3);
      count_to(0, n); chk("d3_tick_period", n, 32'd3);
      count_to(1, n); chk("d3_first_bit", n, 32'd42);
      count_to(2, n); chk("d3_bit_to_mid", n, 32'd24);
      count_to(1, n); chk("d3_mid_to_bit", n, 32'd24);

      // Divisor 0 is clamped to 1: TICK on every edge.
      DIV_LOAD = 1'b1; DIV_IN = 16'd0; step(); DIV_LOAD = 1'b0;
      chk("d0_div", DIV_OUT, 32'd1);
      chk("d0_tick_low", TICK, 32'd0);
      step(); chk("d0_tick1", TICK, 32'd1);
      step(); chk("d0_tick2", TICK, 32'd1);
      count_to(2, n); chk("d0_first_mid", n, 32'd6);
      count_to(1, n); chk("d0_first_bit", n, 32'd8);
      count_to(1, n); chk("d0_bit_period", n, 32'd16);

      // Divisor 5, EN gap of 7 cycles with cnt=3, sub=2.
      DIV_LOAD = 1'b1; DIV_IN = 16'd5; step(); DIV_LOAD = 1'b0;
      count_to(0, n); chk("d5_first_tick", n, 32'd5);
      count_to(0, n); chk("d5_tick_period", n, 32'd5);
      steps(3);
      EN = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("gap_no_strobe", {29'd0, TICK, BIT_TICK, MID_TICK}, 32'd0);
      end
      EN = 1'b1;
      count_to(0, n); chk("gap_resume_tick", n, 32'd2);
      // sub=3 now; MID follows tick 8, five ticks later.
      count_to(2, n); chk("gap_sub_kept", n, 32'd25);

      // PHASE_RST with sub=9 and cnt=2.
      count_to(0, n); chk("pr_pre_tick", n, 32'd5);
      steps(2);
      PHASE_RST = 1'b1; step(); PHASE_RST = 1'b0;
      chk("pr_strobes", {29'd0, TICK, BIT_TICK, MID_TICK}, 32'd0);
      chk("pr_div", DIV_OUT, 32'd5);
      count_to(0, n); chk("pr_first_tick", n, 32'd5);
      count_to(2, n); chk("pr_mid", n, 32'd35);
      count_to(1, n); chk("pr_bit", n, 32'd40);

      // DIV_LOAD with PHASE_RST on a would-be tick edge (cnt=4 of 5).
      steps(4);
      DIV_LOAD = 1'b1; PHASE_RST = 1'b1; DIV_IN = 16'd3; step();
      DIV_LOAD = 1'b0; PHASE_RST = 1'b0;
      chk("ld_tick_suppressed", TICK, 32'd0);
      chk("ld_wins_div", DIV_OUT, 32'd3);
      count_to(0, n); chk("ld_first_tick", n, 32'd3);
      count_to(1, n); chk("ld_first_bit", n, 32'd45);

      // Reset mid-period with a DIV_LOAD that must be ignored.
      step();
      reset = 1'b0; DIV_LOAD = 1'b1; DIV_IN = 16'd7; step();
      chk("rst2_strobes", {29'd0, TICK, BIT_TICK, MID_TICK}, 32'd0);
      step();
      reset = 1'b1; DIV_LOAD = 1'b0;
      chk("rst2_div", DIV_OUT, 32'd260);
      chk("rst2_strobes_after", {29'd0, TICK, BIT_TICK, MID_TICK}, 32'd0);
      count_to(0, n); chk("rst2_first_tick", n, 32'd260);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
